mips_store_checker: RTL and testbench
=====================================

# mips_store_checker

Synthesisable, self-checking monitor for the single-cycle MIPS data-memory write port. It holds a programmable table of up to NUM_CHECKS expected (address, data) stores and checks every store the core issues against that table, in order. It reports pass, the failure cause or a timeout through registered status outputs. It sits beside the core on the DATA_MEM_WR_EN / ALU_Result / reg_file_RD2 nets, so the same check can run in simulation, emulation and on FPGA.

## Interface
- ADDR_WIDTH, 32, store address width
- DATA_WIDTH, 32, store data width
- NUM_CHECKS, 4, expected-store table depth (≥1); IW = $clog2(NUM_CHECKS), CW = $clog2(NUM_CHECKS+1)
- TIMEOUT_CYCLES, 1024, RUN cycles allowed before timeout (≥2); TW = $clog2(TIMEOUT_CYCLES+1)
- IGNORE_BASE, 80, base of the ignored store window (used only with the macro)
- IGNORE_MASK, 'hFFFF_FFFF, address bits compared against IGNORE_BASE

- CLK  in  1  clock; all logic on the rising edge
- RST_N  in  1  reset, synchronous, active-low
- cfg_wr_en  in  1  write one table entry (accepted only in IDLE)
- cfg_idx  in  IW  table index
- cfg_addr  in  ADDR_WIDTH  expected address
- cfg_data  in  DATA_WIDTH  expected data
- cfg_count  in  CW  number of active entries, latched at start; values >NUM_CHECKS are clamped
- start  in  1  begin a run (accepted in IDLE, PASS or FAIL)
- DATA_MEM_WR_EN  in  1  core store strobe
- ALU_Result  in  ADDR_WIDTH  store address
- reg_file_RD2  in  DATA_WIDTH  store data
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- match_count  out  CW  number of entries matched so far
- fail_addr / fail_data  out  ADDR_WIDTH / DATA_WIDTH  store that caused the failure; 0 for timeout

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE
  - cfg_wr_en writes table[cfg_idx]; an out-of-range idx is ignored.
  - start → RUN; latches cfg_count; clears match_count and the cycle counter.
- RUN
  - Each edge with DATA_MEM_WR_EN=1 compares the store with table[match_count].
  - Address and data equal → match_count+1; if the new count equals the latched count → PASS.
  - Address differs → FAIL, code 1. Address equal, data differs → FAIL, code 2.
  - fail_addr and fail_data capture the offending store.
- RUN with a latched count of 0 → PASS on the first RUN edge.
- No further stores are checked after PASS.
- PASS/FAIL are sticky. A start from PASS or FAIL re-runs with the retained table; it clears fail_* and match_count and re-latches cfg_count.
- start while in RUN is ignored. cfg_wr_en outside IDLE is ignored.
- Return to IDLE only through reset.

## Timing
- Reset (RST_N=0 on an edge) → IDLE on that edge:
  - all outputs 0;
  - table, latched count and cycle counter cleared.
- Reset mid-run aborts with no pass/fail.
- Store check latency is one edge. A store sampled at edge N shows in match_count, done, pass and fail_* after edge N.
- start sampled at edge N → busy=1 after edge N. The first store checked is the one sampled at edge N+1.
- The cycle counter increments every RUN edge. If it reaches TIMEOUT_CYCLES-1 without completion → FAIL, code 3.
- Simultaneous events:
  - the final matching store on the timeout edge → PASS (the match wins);
  - a mismatch on the timeout edge → code 1 or 2 (the mismatch wins).
- Comparisons are full-width and unsigned. The counters saturate and never wrap.

## Configuration
- Macro MIPS_STORE_CHECKER_IGNORE_EN.
- Defined: in RUN, a store with (ALU_Result & IGNORE_MASK) == (IGNORE_BASE & IGNORE_MASK) is skipped. It is neither a match nor a failure, and it takes priority over table comparison.
- Undefined: IGNORE_BASE and IGNORE_MASK are unused, and every store is compared against the table.

## Test plan
- Macro on, IGNORE_BASE=80, table[0]={84,7}, cfg_count=1, start. Stores (80,3), (80,9), (84,7) → pass=1 and match_count=1 one edge after (84,7); fail_code=0.
- Same table, store (88,7) → FAIL, fail_code=1, fail_addr=88, fail_data=7, done=1, pass=0.
- Same table, store (84,6) → fail_code=2, fail_data=6.
- TIMEOUT_CYCLES=16, no stores after start → fail_code=3 after exactly 15 RUN edges. A variant with (84,7) on that 15th edge → pass=1.
- cfg_count=0, start → pass=1 one edge after busy. A second start → busy=1 again, then PASS.
- Mid-run: table[0..1]={84,7},{88,5}, cfg_count=2, store (84,7), then RST_N=0 for one edge → all outputs 0 and the table cleared; a following start with cfg_count=1 and store (0,0) → PASS.

Source files
------------

// File: rtl/mips_store_checker.sv
// mips_store_checker: in-order checker for the single-cycle MIPS data-memory
// write port. A programmable table of expected (address, data) stores is
// compared against each store the core issues. The result is reported as
// pass, a failure cause, or a timeout.
// Optional feature: define MIPS_STORE_CHECKER_IGNORE_EN to skip stores whose
// masked address equals IGNORE_BASE (masked by IGNORE_MASK).
module mips_store_checker #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [ADDR_WIDTH-1:0] IGNORE_BASE = ADDR_WIDTH'(80),
  parameter logic [ADDR_WIDTH-1:0] IGNORE_MASK = '1,
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CW = $clog2(NUM_CHECKS + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cfg_wr_en,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic [CW-1:0]         cfg_count,
  input  logic                  start,
  input  logic                  DATA_MEM_WR_EN,
  input  logic [ADDR_WIDTH-1:0] ALU_Result,
  input  logic [DATA_WIDTH-1:0] reg_file_RD2,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [CW-1:0]         match_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ADDR    = 2'd1;
  localparam logic [1:0] FC_DATA    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam logic [TW-1:0] CYC_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(NUM_CHECKS);

`ifdef MIPS_STORE_CHECKER_IGNORE_EN
  localparam bit IGNORE_ON = 1'b1;
`else
  localparam bit IGNORE_ON = 1'b0;
`endif

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt_lat, cnt_lat_nx;
  logic [TW-1:0]           cyc, cyc_nx;
  logic [CW-1:0]           match_nx;
  logic [1:0]              fc_nx;
  logic [ADDR_WIDTH-1:0]   fa_nx;
  logic [DATA_WIDTH-1:0]   fd_nx;

  logic [ADDR_WIDTH-1:0]   tbl_addr [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   tbl_data [NUM_CHECKS];
  logic [ADDR_WIDTH-1:0]   exp_addr;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    ignore_hit;
  logic                    timeout_hit;

  // Saturating increment of the cycle counter; it parks at the timeout limit.
  function automatic logic [TW-1:0] sat_inc_cyc(input logic [TW-1:0] v);
    return (v == CYC_LIMIT) ? v : v + 1'b1;
  endfunction

  // Saturating increment of the match counter; it never exceeds the table depth.
  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Requested active-entry count clamped to the table depth.
  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] v);
    return (int'(v) > NUM_CHECKS) ? CNT_MAX : v;
  endfunction

  assign exp_addr    = tbl_addr[match_count[IW-1:0]];
  assign exp_data    = tbl_data[match_count[IW-1:0]];
  assign ignore_hit  = IGNORE_ON &&
                       ((ALU_Result & IGNORE_MASK) == (IGNORE_BASE & IGNORE_MASK));
  assign timeout_hit = (cyc_nx == CYC_LIMIT);

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

  // Expected-store table: cleared by reset, writable only while idle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (state == S_IDLE && cfg_wr_en && int'(cfg_idx) < NUM_CHECKS) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  // State register plus run bookkeeping and registered status.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      cnt_lat     <= '0;
      cyc         <= '0;
      match_count <= '0;
      fail_code   <= FC_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state       <= state_nx;
      cnt_lat     <= cnt_lat_nx;
      cyc         <= cyc_nx;
      match_count <= match_nx;
      fail_code   <= fc_nx;
      fail_addr   <= fa_nx;
      fail_data   <= fd_nx;
    end
  end

  // Next-state and status logic; a match or mismatch outranks the timeout.
  always_comb begin
    state_nx   = state;
    cnt_lat_nx = cnt_lat;
    cyc_nx     = cyc;
    match_nx   = match_count;
    fc_nx      = fail_code;
    fa_nx      = fail_addr;
    fd_nx      = fail_data;
    case (state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_nx   = S_RUN;
          cnt_lat_nx = clamp_cnt(cfg_count);
          cyc_nx     = '0;
          match_nx   = '0;
          fc_nx      = FC_NONE;
          fa_nx      = '0;
          fd_nx      = '0;
        end
      end
      S_RUN: begin
        cyc_nx = sat_inc_cyc(cyc);
        if (cnt_lat == '0) begin
          state_nx = S_PASS;
        end else if (DATA_MEM_WR_EN && !ignore_hit) begin
          if (ALU_Result != exp_addr) begin
            state_nx = S_FAIL;
            fc_nx    = FC_ADDR;
            fa_nx    = ALU_Result;
            fd_nx    = reg_file_RD2;
          end else if (reg_file_RD2 != exp_data) begin
            state_nx = S_FAIL;
            fc_nx    = FC_DATA;
            fa_nx    = ALU_Result;
            fd_nx    = reg_file_RD2;
          end else begin
            match_nx = sat_inc_cnt(match_count);
            if (match_nx == cnt_lat) begin
              state_nx = S_PASS;
            end else if (timeout_hit) begin
              state_nx = S_FAIL;
              fc_nx    = FC_TIMEOUT;
            end
          end
        end else if (timeout_hit) begin
          state_nx = S_FAIL;
          fc_nx    = FC_TIMEOUT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_store_checker.sv
// Directed bench for mips_store_checker with hand-computed expectations.
// Runs with TIMEOUT_CYCLES=16; adapts the ignore-window scenario to whether
// MIPS_STORE_CHECKER_IGNORE_EN is defined.
module tb_mips_store_checker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          start = 1'b0;
  logic          DATA_MEM_WR_EN = 1'b0;
  logic [AW-1:0] ALU_Result = '0;
  logic [DW-1:0] reg_file_RD2 = '0;
  logic          busy, done, pass;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  int n_checks = 0;
  int n_errors = 0;

  mips_store_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(16),
    .IGNORE_BASE(32'd80), .IGNORE_MASK(32'hFFFF_FFFF)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
    .DATA_MEM_WR_EN(DATA_MEM_WR_EN), .ALU_Result(ALU_Result), .reg_file_RD2(reg_file_RD2),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_count(match_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input int a, input int d);
    cfg_wr_en = 1'b1; cfg_idx = IW'(idx); cfg_addr = AW'(a); cfg_data = DW'(d);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_start(input int cnt);
    cfg_count = CW'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    DATA_MEM_WR_EN = 1'b1; ALU_Result = AW'(a); reg_file_RD2 = DW'(d);
    tick();
    DATA_MEM_WR_EN = 1'b0;
  endtask

  task automatic chk_status(input string tag, input bit b, input bit dn, input bit p,
                            input int fc, input int mc);
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".pass"}, 64'(pass), 64'(p));
    chk({tag, ".code"}, 64'(fail_code), 64'(fc));
    chk({tag, ".mcnt"}, 64'(match_count), 64'(mc));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_status("rst", 0, 0, 0, 0, 0);
    chk("rst.faddr", 64'(fail_addr), 0);
    chk("rst.fdata", 64'(fail_data), 0);

    cfg_write(0, 84, 7);
    cfg_write(1, 88, 5);
    cfg_write(2, 92, 1);
    cfg_write(3, 96, 2);

`ifdef MIPS_STORE_CHECKER_IGNORE_EN
    // Ignored stores are neither match nor failure
    do_start(1);
    chk_status("ign.start", 1, 0, 0, 0, 0);
    store(80, 3);
    chk_status("ign.s1", 1, 0, 0, 0, 0);
    store(80, 9);
    chk_status("ign.s2", 1, 0, 0, 0, 0);
    store(84, 7);
    chk_status("ign.pass", 0, 1, 1, 0, 1);
`else
    // Without the ignore window, a store to 80 is an address mismatch
    do_start(1);
    chk_status("noign.start", 1, 0, 0, 0, 0);
    store(80, 3);
    chk_status("noign.fail", 0, 1, 0, 1, 0);
    chk("noign.faddr", 64'(fail_addr), 80);
    chk("noign.fdata", 64'(fail_data), 3);
    do_start(1);
    store(84, 7);
    chk_status("basic.pass", 0, 1, 1, 0, 1);
`endif
    // No checking after PASS
    store(88, 7);
    chk_status("pass.sticky", 0, 1, 1, 0, 1);

    // Address mismatch
    do_start(1);
    chk_status("amis.start", 1, 0, 0, 0, 0);
    store(88, 7);
    chk_status("amis", 0, 1, 0, 1, 0);
    chk("amis.faddr", 64'(fail_addr), 88);
    chk("amis.fdata", 64'(fail_data), 7);

    // Restart from FAIL clears failure info; then data mismatch
    do_start(1);
    chk_status("dmis.start", 1, 0, 0, 0, 0);
    chk("dmis.start.faddr", 64'(fail_addr), 0);
    store(84, 6);
    chk_status("dmis", 0, 1, 0, 2, 0);
    chk("dmis.faddr", 64'(fail_addr), 84);
    chk("dmis.fdata", 64'(fail_data), 6);

    // Timeout after exactly 15 RUN edges
    do_start(1);
    for (int i = 0; i < 14; i++) tick();
    chk_status("to.edge14", 1, 0, 0, 0, 0);
    tick();
    chk_status("to.edge15", 0, 1, 0, 3, 0);
    chk("to.faddr", 64'(fail_addr), 0);
    chk("to.fdata", 64'(fail_data), 0);

    // Final match on the timeout edge wins
    do_start(1);
    for (int i = 0; i < 14; i++) tick();
    store(84, 7);
    chk_status("to.match", 0, 1, 1, 0, 1);

    // Mismatch on the timeout edge wins
    do_start(1);
    for (int i = 0; i < 14; i++) tick();
    store(84, 6);
    chk_status("to.mis", 0, 1, 0, 2, 0);

    // Zero-length run passes on first RUN edge, twice
    do_start(0);
    chk_status("zero.start", 1, 0, 0, 0, 0);
    tick();
    chk_status("zero.pass", 0, 1, 1, 0, 0);
    do_start(0);
    chk_status("zero.start2", 1, 0, 0, 0, 0);
    tick();
    chk_status("zero.pass2", 0, 1, 1, 0, 0);

    // Oversized count is clamped to the table depth
    do_start(7);
    store(84, 7);
    store(88, 5);
    store(92, 1);
    chk_status("clamp.m3", 1, 0, 0, 0, 3);
    store(96, 2);
    chk_status("clamp.pass", 0, 1, 1, 0, 4);

    // start and cfg writes during RUN are ignored
    do_start(2);
    store(84, 7);
    chk_status("run.m1", 1, 0, 0, 0, 1);
    start = 1'b1; cfg_count = 3'd1;
    tick();
    start = 1'b0;
    chk_status("run.startign", 1, 0, 0, 0, 1);
    cfg_write(1, 100, 100);
    store(88, 5);
    chk_status("run.cfgign", 0, 1, 1, 0, 2);

    // Reset mid-run aborts and clears the table
    do_start(2);
    store(84, 7);
    chk_status("mid.m1", 1, 0, 0, 0, 1);
    do_reset();
    chk_status("mid.rst", 0, 0, 0, 0, 0);
    chk("mid.rst.faddr", 64'(fail_addr), 0);
    do_start(1);
    store(0, 0);
    chk_status("mid.clr", 0, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
